// File: rtl/ascii_conv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ascii_conv_arbiter
// Purpose  : Round-robin sharing of one combinational ASCII converter between
//            two byte requesters, with a one-entry valid/ready output stage and
//            saturating per-requester Cap counters.
// Revision : 1.0 - initial release
// ============================================================================
module ascii_conv_arbiter #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic [DATA_W-1:0] data0,
  output logic              ack0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data1,
  output logic              ack1,
  output logic [DATA_W-1:0] conv_in,
  input  logic [DATA_W-1:0] conv_out,
  input  logic              conv_cap,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_cap,
  output logic              out_src,
  input  logic              clr,
  output logic [CNT_W-1:0]  cap_cnt0,
  output logic [CNT_W-1:0]  cap_cnt1
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_cap_q,   out_cap_d;
  logic              out_src_q,   out_src_d;
  logic              last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cap_cnt0_q,  cap_cnt0_d;
  logic [CNT_W-1:0]  cap_cnt1_q,  cap_cnt1_d;

  logic w_acc, w_grant0, w_grant1, w_any;

  // Under contention the requester that did not win last time is served.
  always_comb begin
    w_acc    = !out_valid_q || out_ready;
    w_grant0 = req0 && (!req1 || last_grant_q);
    w_grant1 = req1 && (!req0 || !last_grant_q);
    ack0     = !reset && w_acc && w_grant0;
    ack1     = !reset && w_acc && w_grant1;
    w_any    = ack0 || ack1;
    if (ack0)      conv_in = data0;
    else if (ack1) conv_in = data1;
    else           conv_in = '0;
  end

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_cap_d    = out_cap_q;
    out_src_d    = out_src_q;
    last_grant_d = last_grant_q;
    cap_cnt0_d   = cap_cnt0_q;
    cap_cnt1_d   = cap_cnt1_q;

    if (w_any) begin
      out_valid_d  = 1'b1;
      out_data_d   = conv_out;
      out_cap_d    = conv_cap;
      out_src_d    = ack1;
      last_grant_d = ack1;
      if (conv_cap && ack0 && cap_cnt0_q != C_CNT_MAX) cap_cnt0_d = cap_cnt0_q + 1'b1;
      if (conv_cap && ack1 && cap_cnt1_q != C_CNT_MAX) cap_cnt1_d = cap_cnt1_q + 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // Clear wins over a same-cycle increment.
    if (clr) begin
      cap_cnt0_d = '0;
      cap_cnt1_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_cap_q    <= 1'b0;
      out_src_q    <= 1'b0;
      last_grant_q <= 1'b1;
      cap_cnt0_q   <= '0;
      cap_cnt1_q   <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_cap_q    <= out_cap_d;
      out_src_q    <= out_src_d;
      last_grant_q <= last_grant_d;
      cap_cnt0_q   <= cap_cnt0_d;
      cap_cnt1_q   <= cap_cnt1_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cap   = out_cap_q;
  assign out_src   = out_src_q;
  assign cap_cnt0  = cap_cnt0_q;
  assign cap_cnt1  = cap_cnt1_q;

endmodule
`default_nettype wire
